// File: rtl/hilo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_pkg : opcode encodings, FSM states and helpers for hilo_seq_ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hilo_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_iter_dp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_iter_dp : one-bit-per-cycle shift-add / restoring-divide engine  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hilo_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             LoadIn,
  input  logic             StepIn,
  input  logic             DivModeIn,
  input  logic [WIDTH-1:0] AMagIn,
  input  logic [WIDTH-1:0] BMagIn,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_opA;
  logic [WIDTH:0]   w_opB;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc;

  // Divide: (partial remainder << 1 | next dividend bit) - divisor; multiply: acc + multiplicand.
  always_comb begin
    w_opA = DivModeIn ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    w_opB = DivModeIn ? ~{1'b0, r_b} : {1'b0, r_b};
    w_sum = w_opA + w_opB + {{WIDTH{1'b0}}, DivModeIn};
    w_acc = r_lo[0] ? w_sum : {1'b0, r_hi};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
      r_b  <= '0;
    end else if (LoadIn) begin
      r_hi <= '0;
      r_lo <= AMagIn;
      r_b  <= BMagIn;
    end else if (StepIn) begin
      if (DivModeIn) begin
        r_hi <= w_sum[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_sum[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_sum[WIDTH]};
      end else begin
        r_hi <= w_acc[WIDTH:1];
        r_lo <= {w_acc[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign HiOut = r_hi;
  assign LoOut = r_lo;

endmodule
`default_nettype wire

// File: rtl/hilo_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hilo_seq_ctrl : multi-cycle MULT/DIV sequencer with HI/LO write strobe|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hilo_seq_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               StartIn,
  input  logic [1:0]         OpIn,
  input  logic [WIDTH-1:0]   AIn,
  input  logic [WIDTH-1:0]   BIn,
  input  logic               HiLoReadIn,
  input  logic               FlushIn,
  output logic               BusyOut,
  output logic               StallOut,
  output logic               HiWriteOut,
  output logic               LoWriteOut,
  output logic [2*WIDTH-1:0] Result64Out,
  output logic               DivZeroOut
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_busy;
  logic                 r_write;
  logic                 r_divZero;
  logic                 w_busyNext;
  logic                 w_writeNext;
  logic                 w_divZeroNext;

  logic [c_CNT_W-1:0]   r_count;
  logic                 r_isDiv;
  logic                 r_negQ;
  logic                 r_negR;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_divZero;
  logic                 w_signA;
  logic                 w_signB;
  logic [WIDTH:0]       w_aExt;
  logic [WIDTH:0]       w_bExt;
  logic [WIDTH-1:0]     w_aMag;
  logic [WIDTH-1:0]     w_bMag;
  logic [WIDTH-1:0]     w_dpHi;
  logic [WIDTH-1:0]     w_dpLo;
  logic [2*WIDTH-1:0]   w_fixed;

  assign w_accept  = (r_state == ST_IDLE) && StartIn && !FlushIn;
  assign w_divZero = is_div(OpIn) && (BIn == '0);
  assign w_signA   = is_signed(OpIn) && AIn[WIDTH-1];
  assign w_signB   = is_signed(OpIn) && BIn[WIDTH-1];

  // Magnitudes are taken in WIDTH+1 bits so the most negative operand stays exact.
  assign w_aExt = {w_signA, AIn};
  assign w_bExt = {w_signB, BIn};
  assign w_aMag = w_signA ? WIDTH'(-w_aExt) : AIn;
  assign w_bMag = w_signB ? WIDTH'(-w_bExt) : BIn;

  hilo_iter_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .LoadIn    (w_accept),
    .StepIn    ((r_state == ST_ITER) && !FlushIn),
    .DivModeIn (r_isDiv),
    .AMagIn    (w_aMag),
    .BMagIn    (w_bMag),
    .HiOut     (w_dpHi),
    .LoOut     (w_dpLo)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_write   <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_busy    <= w_busyNext;
      r_write   <= w_writeNext;
      r_divZero <= w_divZeroNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (FlushIn) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (StartIn) w_nextState = w_divZero ? ST_WB : ST_ITER;
        ST_ITER: if (r_count == c_LAST) w_nextState = ST_FIX;
        ST_FIX:  w_nextState = ST_WB;
        ST_WB:   w_nextState = ST_IDLE;
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they leave flops directly.
  always_comb begin
    w_busyNext    = 1'b0;
    w_writeNext   = 1'b0;
    w_divZeroNext = 1'b0;
    if (w_nextState != ST_IDLE) w_busyNext = 1'b1;
    if (w_nextState == ST_WB)   w_writeNext = 1'b1;
    if (w_accept && w_divZero)  w_divZeroNext = 1'b1;
  end

  always_comb begin
    w_fixed = {w_dpHi, w_dpLo};
    if (r_isDiv) begin
      w_fixed[WIDTH-1:0]       = r_negQ ? -w_dpLo : w_dpLo;
      w_fixed[2*WIDTH-1:WIDTH] = r_negR ? -w_dpHi : w_dpHi;
    end else if (r_negQ) begin
      w_fixed = -{w_dpHi, w_dpLo};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count  <= '0;
      r_isDiv  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_count <= '0;
        r_isDiv <= is_div(OpIn);
        r_negQ  <= w_signA ^ w_signB;
        r_negR  <= w_signA;
        if (w_divZero) r_result <= {AIn, {WIDTH{1'b1}}};
      end else if (r_state == ST_ITER) begin
        r_count <= r_count + c_CNT_W'(1);
      end
      if ((r_state == ST_FIX) && !FlushIn) r_result <= w_fixed;
    end
  end

  assign BusyOut     = r_busy;
  assign StallOut    = r_busy && (HiLoReadIn || StartIn);
  assign HiWriteOut  = r_write;
  assign LoWriteOut  = r_write;
  assign Result64Out = r_result;
  assign DivZeroOut  = r_divZero;

endmodule
`default_nettype wire

// File: tb/tb_hilo_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hilo_seq_ctrl : randomized and directed bench for hilo_seq_ctrl    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hilo_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        StartIn = 1'b0;
  logic [1:0]  OpIn = 2'b00;
  logic [31:0] AIn = '0;
  logic [31:0] BIn = '0;
  logic        HiLoReadIn = 1'b0;
  logic        FlushIn = 1'b0;
  logic        BusyOut;
  logic        StallOut;
  logic        HiWriteOut;
  logic        LoWriteOut;
  logic [63:0] Result64Out;
  logic        DivZeroOut;

  int total = 0;
  int bad   = 0;

  hilo_seq_ctrl #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .StartIn     (StartIn),
    .OpIn        (OpIn),
    .AIn         (AIn),
    .BIn         (BIn),
    .HiLoReadIn  (HiLoReadIn),
    .FlushIn     (FlushIn),
    .BusyOut     (BusyOut),
    .StallOut    (StallOut),
    .HiWriteOut  (HiWriteOut),
    .LoWriteOut  (LoWriteOut),
    .Result64Out (Result64Out),
    .DivZeroOut  (DivZeroOut)
  );

  always #5 Clk = ~Clk;

  // Reference: {divzero, HI, LO} from plain 64-bit integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
    endcase
    return {1'b0, r};
  endfunction

  // Issues one operation and watches 40 edges; lat = edges from acceptance to strobe + 1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output logic dz, output int lat,
                       output int nHi, output int nLo, output logic busyAfter);
    res = '0; dz = 1'b0; lat = -1; nHi = 0; nLo = 0; busyAfter = 1'b1;
    @(negedge Clk);
    StartIn = 1'b1; OpIn = op; AIn = a; BIn = b;
    @(posedge Clk); #1;
    StartIn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (HiWriteOut) nHi++;
      if (LoWriteOut) nLo++;
      if (HiWriteOut && lat < 0) begin
        lat = k + 1; res = Result64Out; dz = DivZeroOut;
      end else if (lat > 0 && k == lat) begin
        busyAfter = BusyOut;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; StartIn = 1'b1; HiLoReadIn = 1'b1; OpIn = 2'b00; AIn = 32'd5; BIn = 32'd3;
    @(posedge Clk); #1;
    total++; if (BusyOut !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BusyOut); end
    total++; if (StallOut !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", StallOut); end
    total++; if (HiWriteOut !== 1'b0 || LoWriteOut !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: got %b%b want 00", HiWriteOut, LoWriteOut); end
    total++; if (DivZeroOut !== 1'b0) begin bad++; $display("FAIL reset_divzero: got %b want 0", DivZeroOut); end
    total++; if (Result64Out !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", Result64Out); end
    @(negedge Clk);
    StartIn = 1'b0; HiLoReadIn = 1'b0; Rst_n = 1'b1;
    @(posedge Clk); #1;
    total++; if (BusyOut !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", BusyOut); end
  endtask

  task automatic test_directed();
    logic [1:0]  vOp  [5];
    logic [31:0] vA   [5];
    logic [31:0] vB   [5];
    logic [63:0] vRes [5];
    logic [63:0] res; logic dz; int lat, nHi, nLo; logic busyAfter;
    vOp  = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01};
    vA   = '{32'hFFFF_FFFE, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    vB   = '{32'd3, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vRes = '{64'hFFFF_FFFF_FFFF_FFFA, 64'h0000_0002_0000_000E, 64'hFFFF_FFFF_FFFF_FFFD,
             64'h0000_0000_8000_0000, 64'hFFFF_FFFE_0000_0001};
    for (int i = 0; i < 5; i++) begin
      do_op(vOp[i], vA[i], vB[i], res, dz, lat, nHi, nLo, busyAfter);
      total++; if (res !== vRes[i]) begin bad++; $display("FAIL directed%0d_result: got %h want %h", i, res, vRes[i]); end
      total++; if (lat != 34) begin bad++; $display("FAIL directed%0d_latency: got %0d want 34", i, lat); end
      total++; if (nHi != 1 || nLo != 1) begin bad++; $display("FAIL directed%0d_strobes: got hi=%0d lo=%0d want 1", i, nHi, nLo); end
      total++; if (busyAfter !== 1'b0) begin bad++; $display("FAIL directed%0d_busy_after: got %b want 0", i, busyAfter); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL directed%0d_divzero: got %b want 0", i, dz); end
    end
  endtask

  task automatic test_divzero();
    logic [63:0] res; logic dz; int lat, nHi, nLo; logic busyAfter; logic [31:0] a;
    do_op(2'b10, 32'd5, 32'd0, res, dz, lat, nHi, nLo, busyAfter);
    total++; if (res !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL dz_result: got %h want 00000005ffffffff", res); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag: got %b want 1", dz); end
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", lat); end
    total++; if (nHi != 1 || nLo != 1) begin bad++; $display("FAIL dz_strobes: got hi=%0d lo=%0d want 1", nHi, nLo); end
    a = $urandom;
    do_op(2'b11, a, 32'd0, res, dz, lat, nHi, nLo, busyAfter);
    total++; if (res !== {a, 32'hFFFF_FFFF} || dz !== 1'b1) begin
      bad++; $display("FAIL dzu_result: got %h dz=%b want %h dz=1", res, dz, {a, 32'hFFFF_FFFF}); end
  endtask

  task automatic test_random();
    logic [63:0] res; logic dz; int lat, nHi, nLo; logic busyAfter;
    logic [1:0] op; logic [31:0] a, b; logic [64:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = ref_model(op, a, b);
      do_op(op, a, b, res, dz, lat, nHi, nLo, busyAfter);
      total++; if (res !== exp[63:0] || dz !== exp[64]) begin
        bad++; $display("FAIL random%0d op=%0d a=%h b=%h: got %h dz=%b want %h dz=%b",
                        i, op, a, b, res, dz, exp[63:0], exp[64]); end
      total++; if (lat != (exp[64] ? 1 : 34) || nHi != 1) begin
        bad++; $display("FAIL random%0d_timing: got lat=%0d n=%0d want lat=%0d n=1",
                        i, lat, nHi, exp[64] ? 1 : 34); end
    end
  endtask

  // Read hazard from cycle 5, second start from cycle 10; second op must wait for IDLE.
  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2; logic [64:0] e1, e2;
    logic [63:0] r1, r2; logic hit1, hit2, busy34, busy35, expStall;
    int nStr, stallErr, firstBad;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'd1;
    e1 = ref_model(2'b00, a1, b1);
    e2 = ref_model(2'b11, a2, b2);
    r1 = '0; r2 = '0; hit1 = 1'b0; hit2 = 1'b0; busy34 = 1'b1; busy35 = 1'b0;
    nStr = 0; stallErr = 0; firstBad = -1;
    @(negedge Clk);
    StartIn = 1'b1; OpIn = 2'b00; AIn = a1; BIn = b1;
    @(posedge Clk); #1;
    StartIn = 1'b0;
    for (int k = 0; k <= 75; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (k == 5) HiLoReadIn = 1'b1;
      if (k == 10) begin StartIn = 1'b1; OpIn = 2'b11; AIn = a2; BIn = b2; end
      if (k == 35) begin StartIn = 1'b0; HiLoReadIn = 1'b0; end
      #1;
      expStall = (k >= 5 && k <= 33);
      if (k <= 34 && StallOut !== expStall) begin
        stallErr++; if (firstBad < 0) firstBad = k; end
      if (HiWriteOut) begin
        nStr++;
        if (k == 33) begin hit1 = 1'b1; r1 = Result64Out; end
        if (k == 68) begin hit2 = 1'b1; r2 = Result64Out; end
      end
      if (k == 34) busy34 = BusyOut;
      if (k == 35) busy35 = BusyOut;
    end
    total++; if (stallErr != 0) begin bad++; $display("FAIL b2b_stall: got %0d wrong cycles (first %0d) want 0", stallErr, firstBad); end
    total++; if (!hit1 || r1 !== e1[63:0]) begin bad++; $display("FAIL b2b_first: got %h hit=%b want %h", r1, hit1, e1[63:0]); end
    total++; if (!hit2 || r2 !== e2[63:0]) begin bad++; $display("FAIL b2b_second: got %h hit=%b want %h", r2, hit2, e2[63:0]); end
    total++; if (nStr != 2) begin bad++; $display("FAIL b2b_strobe_count: got %0d want 2", nStr); end
    total++; if (busy34 !== 1'b0 || busy35 !== 1'b1) begin
      bad++; $display("FAIL b2b_gap: got busy34=%b busy35=%b want 0 1", busy34, busy35); end
  endtask

  task automatic test_flush();
    logic [63:0] res; logic dz; int lat, nHi, nLo; logic busyAfter;
    logic [31:0] a, b; logic [64:0] exp; int nStr; logic busy10, busy11, anyBusy;
    nStr = 0; busy10 = 1'b0; busy11 = 1'b1; anyBusy = 1'b0;
    @(negedge Clk);
    StartIn = 1'b1; OpIn = 2'b11; AIn = $urandom; BIn = $urandom | 32'd1;
    @(posedge Clk); #1;
    StartIn = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge Clk); #1;
      if (k == 10) busy10 = BusyOut;
      if (k == 11) begin busy11 = BusyOut; FlushIn = 1'b0; end
      if (HiWriteOut) nStr++;
      if (k == 10) FlushIn = 1'b1;
    end
    total++; if (busy10 !== 1'b1 || busy11 !== 1'b0) begin
      bad++; $display("FAIL flush_iter: got busy10=%b busy11=%b want 1 0", busy10, busy11); end
    total++; if (nStr != 0) begin bad++; $display("FAIL flush_iter_strobe: got %0d want 0", nStr); end
    nStr = 0;
    @(negedge Clk);
    StartIn = 1'b1; FlushIn = 1'b1; OpIn = 2'b00; AIn = $urandom; BIn = $urandom;
    @(posedge Clk); #1;
    StartIn = 1'b0; FlushIn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if (BusyOut) anyBusy = 1'b1;
      if (HiWriteOut) nStr++;
    end
    total++; if (anyBusy !== 1'b0 || nStr != 0) begin
      bad++; $display("FAIL flush_idle_start: got busy=%b strobes=%0d want 0 0", anyBusy, nStr); end
    a = $urandom; b = $urandom;
    exp = ref_model(2'b01, a, b);
    do_op(2'b01, a, b, res, dz, lat, nHi, nLo, busyAfter);
    total++; if (res !== exp[63:0] || lat != 34) begin
      bad++; $display("FAIL flush_recover: got %h lat=%0d want %h lat=34", res, lat, exp[63:0]); end
  endtask

  task automatic test_async_reset();
    logic [63:0] res; logic dz; int lat, nHi, nLo; logic busyAfter; int nStr; logic anyBusy;
    nStr = 0; anyBusy = 1'b0;
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, dz, lat, nHi, nLo, busyAfter);
    total++; if (res !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL minint_div: got %h want 0000000080000000", res); end
    @(negedge Clk);
    StartIn = 1'b1; OpIn = 2'b00; AIn = $urandom | 32'd1; BIn = $urandom | 32'd1; HiLoReadIn = 1'b1;
    @(posedge Clk); #1;
    StartIn = 1'b0;
    for (int k = 1; k <= 12; k++) begin @(posedge Clk); #1; end
    #3;
    Rst_n = 1'b0;
    #1;
    total++; if (BusyOut !== 1'b0 || StallOut !== 1'b0) begin
      bad++; $display("FAIL areset_busy_stall: got %b %b want 0 0", BusyOut, StallOut); end
    total++; if (HiWriteOut !== 1'b0 || LoWriteOut !== 1'b0 || DivZeroOut !== 1'b0) begin
      bad++; $display("FAIL areset_strobes: got %b%b%b want 000", HiWriteOut, LoWriteOut, DivZeroOut); end
    total++; if (Result64Out !== 64'd0) begin bad++; $display("FAIL areset_result: got %h want 0", Result64Out); end
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1; HiLoReadIn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (BusyOut) anyBusy = 1'b1;
      if (HiWriteOut) nStr++;
    end
    total++; if (anyBusy !== 1'b0 || nStr != 0) begin
      bad++; $display("FAIL areset_after_release: got busy=%b strobes=%0d want 0 0", anyBusy, nStr); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/hilo_seq_ctrl.md
# hilo_seq_ctrl

Multi-cycle HI/LO sequencer for the MIPS pipeline: accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a one-bit-per-cycle shift-add / restoring-divide datapath, and produces a one-cycle HI/LO write strobe with the 64-bit result.
- It stalls the front of the pipeline while the HI/LO registers are not yet valid.
- It sits beside the ALU and feeds the 64-bit result path that travels through EX/MEM and MEM/WB into the Hi/Lo registers.

## Interface
Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset, asynchronous and active-low.
- StartIn  in  1  EX stage holds a valid mult/div instruction.
- OpIn  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- AIn, BIn  in  WIDTH  rs and rt operands; B is the divisor.
- HiLoReadIn  in  1  ID stage instruction reads HI/LO (mfhi/mflo) or is another mult/div.
- FlushIn  in  1  abort the in-flight operation, for branch or exception.
- BusyOut  out  1  operation in flight.
- StallOut  out  1  freeze PC, IF/ID and ID/EX.
- HiWriteOut, LoWriteOut  out  1  one-cycle write strobes.
- Result64Out  out  2*WIDTH  {HI,LO}; valid while the strobes are high.
- DivZeroOut  out  1  pulses together with the strobes when a divide has B==0.

## Operation
- FSM states: IDLE, ITER, FIX, WB.
- IDLE, StartIn=1 and FlushIn=0:
  - Latch |A|, |B| (absolute values for the signed ops; raw values for the unsigned ops), OpIn, and the result signs.
  - Clear the iteration counter and go to ITER.
- IDLE, divide with B==0: go straight to WB with HI=A, LO=all ones, DivZeroOut=1.
- ITER: one iteration per cycle; after WIDTH iterations go to FIX.
  - Multiply: shift-add on a {acc, multiplier} register.
  - Divide: restoring division; the quotient shifts into LO and the remainder accumulates in HI.
- FIX, sign correction, one cycle, then go to WB:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned ops: no change.
- WB: assert HiWriteOut=LoWriteOut=1 and Result64Out valid, then go to IDLE.
- BusyOut=1 in ITER, FIX and WB.
- StallOut = BusyOut & (HiLoReadIn | StartIn).
  - A new StartIn while busy is held by the stall and is never accepted mid-operation.
  - In WB the stall is still asserted; the dependent instruction proceeds the next cycle and reads the written HI/LO.
- FlushIn=1 in any state: go to IDLE on the next edge with no strobe. It takes priority over StartIn in the same cycle.
- StartIn and FlushIn both high in IDLE: the start is discarded.
- Arithmetic rules:
  - The two's-complement minimum is handled by absolute value in WIDTH+1 bits; 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
  - All subtracts are WIDTH+1 bits wide.

## Timing
- Start accepted at edge E0, normal operation:
  - ITER at edges E1..E32.
  - FIX at E33.
  - Strobes high in the cycle after E33 (34-cycle latency); return to IDLE at E34.
- Divide by zero: strobes high in the cycle after E0 (1-cycle latency).
- Back-to-back: a start presented in the WB cycle is stalled. It is accepted at the first IDLE edge, so there is a minimum gap of one cycle between operations.
- Reset (Rst_n=0), asynchronous and allowed at any time including mid-ITER:
  - State goes to IDLE; counter and operand/result registers go to 0.
  - BusyOut, StallOut, HiWriteOut, LoWriteOut and DivZeroOut are 0; Result64Out is 0.
  - No strobe is issued after release.
- All outputs are registered except StallOut, which is combinational from BusyOut and the inputs.

## Structure
- Package hilo_pkg holds:
  - The OpIn encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - The state enum.
  - The is_div and is_signed helper functions.
- One sub-module, hilo_iter_dp: the WIDTH+1-bit adder/subtractor and the 2*WIDTH shift register, one step per cycle, controlled by a step/mode signal from the FSM.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3 -> 34 cycles later HI=0xFFFFFFFF, LO=0xFFFFFFFA, single strobe, BusyOut low the next cycle.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=5, B=0 -> strobes one cycle after the start with DivZeroOut=1, HI=5, LO=0xFFFFFFFF.
- Start, then HiLoReadIn=1 at cycle 5 -> StallOut=1 through the WB cycle, 0 after; a second StartIn during ITER is ignored until IDLE.
- FlushIn at ITER cycle 10 -> IDLE next edge, no strobe. Start+flush in the same IDLE cycle -> nothing starts.
- Rst_n pulsed low mid-ITER (asynchronous, between edges) -> all outputs 0 immediately, IDLE, no strobe after release; 0x80000000 / -1 signed -> LO=0x80000000, HI=0.
